vga_scanout: RTL and testbench
==============================

VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BP, 33, vertical back porch.
REQ-002 Ports (name, direction, width, meaning), one per line; reset rst, asynchronous, active-high; clock clk:
- clk  in  1  pixel clock, one pixel per cycle.
- rst  in  1  asynchronous, active-high reset.
- fifo_data  in  24  pixel at the FIFO head, {R[23:16],G[15:8],B[7:0]}; first-word-fall-through, valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO has no data.
- read_en  out  1  pops the FIFO head this cycle (combinational).
- hsync  out  1  horizontal sync, active-low.
- vsync  out  1  vertical sync, active-low.
- blank  out  1  high outside the visible area.
- rgb  out  24  pixel output.
- underflow  out  1  sticky: a visible pixel found the FIFO empty.

Function
REQ-003 States: IDLE and RUN. In IDLE, h_cnt=0, v_cnt=0, read_en=0 and outputs stay at reset values; IDLE→RUN on the first cycle with fifo_empty=0.
REQ-004 RUN: h_cnt counts 0..799 (H total = sum of H params). At 799 it wraps to 0 and increments v_cnt, which counts 0..524 and wraps to 0. RUN is never left except by rst.
REQ-005 Visible area: h_cnt<640 and v_cnt<480.
REQ-006 read_en = (state==RUN) & visible & ~fifo_empty; never asserted outside the visible area.
REQ-007 Sync windows (from counter values):
- hsync low for 656≤h_cnt<752.
- vsync low for 490≤v_cnt<492.
REQ-008 Output latency is exactly 1 cycle: hsync, vsync, blank and rgb are registered from the counter values and data of the previous cycle.
REQ-009 rgb = fifo_data when read_en was 1 the previous cycle; otherwise 24'h000000.
REQ-010 A visible cycle with fifo_empty=1: rgb is black for that pixel, no pop, and underflow is set. The pixel is skipped, not delayed; counters do not stall.
REQ-011 underflow, once set, holds until rst.
REQ-012 Exactly 307200 pops per frame when no underflow occurs, matching the upstream 640x480 writer order: row-major, starting at the frame's first pixel.
REQ-013 Arithmetic: h_cnt is 10 bits, v_cnt is 10 bits. Wrap uses compare-to-total, not overflow.

Reset
REQ-014 rst asserted, including mid-frame, immediately gives:
- state=IDLE, h_cnt=0, v_cnt=0.
- hsync=1, vsync=1, blank=1, rgb=0, underflow=0, read_en=0.
REQ-015 After rst deassertion, no output changes until fifo_empty is first low.

Structure
REQ-016 A shared package vga_timing_pkg holds the 640x480@60 timing constants (actives, porches, syncs, totals) and the 24-bit pixel type, so the upstream writer and this block share them.
REQ-017 One sub-module, vga_timing_gen, SHALL contain the h/v counters plus the sync and visible decode. vga_scanout adds the FSM, FIFO handshake, output registers and underflow flag.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Reset, FIFO empty for 100 cycles: hsync=vsync=blank=1, rgb=0, read_en=0 throughout.
- FIFO always non-empty with incrementing data: first visible rgb=data[0] one cycle after entering RUN; 640 pops per line; 307200 pops per frame; hsync low 96 cycles starting 657 cycles after line start; line period 800; frame period 420000 cycles.
- fifo_empty forced high for 5 cycles at h_cnt=100, v_cnt=10: rgb=0 for those 5 pixels, no pops, underflow=1 and stays 1 for the next full frame.
- fifo_empty high only during blanking: read_en=0, underflow stays 0.
- rst pulse at h_cnt=300, v_cnt=200: all outputs at reset values on the next edge; after release and FIFO non-empty, scan restarts at h_cnt=0, v_cnt=0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared 640x480@60 timing constants and the 24-bit pixel type. The upstream
// frame writer and the scanout block both import this package, so they agree
// on frame geometry and pixel layout.
// No ports (package only).
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int CNT_W   = 10;
  localparam int PIXEL_W = 24;

  // {R[23:16], G[15:8], B[7:0]}
  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Horizontal/vertical position counters plus sync-window and visible-area
// decode. The counters only move while 'advance' is high, so the scanout FSM
// can hold them at the origin until the first pixel is available.
// Ports:
//   clk, rst  pixel clock, asynchronous active-high reset
//   advance   step the scan position by one pixel this cycle
//   visible   current position lies inside the active area (combinational)
//   hsync_n   current position lies outside the hsync window (active-low)
//   vsync_n   current position lies outside the vsync window (active-low)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  output logic visible,
  output logic hsync_n,
  output logic vsync_n
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  // Wrap is an explicit compare against the line/frame total, never a
  // natural counter overflow, so any total that fits in CNT_W bits works.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (advance) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hsync_n = ~((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vsync_n = ~((v_cnt >= VS_START) && (v_cnt < VS_END));

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout
// Streams pixels from a first-word-fall-through FIFO onto a VGA raster.
// Waits in IDLE until the FIFO first holds data, then scans forever; a
// visible pixel that finds the FIFO empty is shown black and skipped, and
// latches the sticky underflow flag.
// Ports:
//   clk, rst    pixel clock, asynchronous active-high reset
//   fifo_data   FIFO head pixel {R,G,B}, valid while fifo_empty is low
//   fifo_empty  FIFO has no data
//   read_en     pop the FIFO head this cycle (combinational)
//   hsync       horizontal sync, active-low, one cycle behind the counters
//   vsync       vertical sync, active-low, one cycle behind the counters
//   blank       high outside the visible area, one cycle behind
//   rgb         pixel output, black unless a pop happened the cycle before
//   underflow   sticky: a visible pixel found the FIFO empty
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIXEL_W-1:0] fifo_data,
  input  logic               fifo_empty,
  output logic               read_en,
  output logic               hsync,
  output logic               vsync,
  output logic               blank,
  output logic [PIXEL_W-1:0] rgb,
  output logic               underflow
);

  scan_state_t state;
  logic        running;
  logic        visible;
  logic        hsync_n;
  logic        vsync_n;

  assign running = (state == RUN);

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk     (clk),
    .rst     (rst),
    .advance (running),
    .visible (visible),
    .hsync_n (hsync_n),
    .vsync_n (vsync_n)
  );

  // Popping is tied to the raster position: an empty FIFO during a visible
  // pixel costs that pixel rather than stalling the scan.
  assign read_en = running & visible & ~fifo_empty;

  // Output registers only update in RUN, so everything holds its reset value
  // from reset release until the FIFO first reports data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      blank     <= 1'b1;
      rgb       <= '0;
      underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) state <= RUN;
        end
        RUN: begin
          hsync <= hsync_n;
          vsync <= vsync_n;
          blank <= ~visible;
          rgb   <= read_en ? fifo_data : '0;
          if (visible && fifo_empty) underflow <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout
// Self-checking bench for vga_scanout. The DUT runs with a shrunken raster
// (30x15 total, 16x8 visible) so several whole frames fit in a short run; all
// expectations are derived from the same geometry constants. A reference
// model tracks only "cycles since the scan started" and derives the raster
// position with division/modulo, checking read_en and every output each cycle.
module tb_vga_scanout;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] fifo_data;
  logic        fifo_empty;
  logic        read_en;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic [23:0] rgb;
  logic        underflow;

  always #5 clk = ~clk;

  vga_scanout #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .read_en    (read_en),
    .hsync      (hsync),
    .vsync      (vsync),
    .blank      (blank),
    .rgb        (rgb),
    .underflow  (underflow)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state
  bit          m_run;
  int          m_t;
  logic        m_hs, m_vs, m_blank, m_uf;
  logic [23:0] m_rgb;

  // Pixel source: incrementing or random words, advanced on each pop
  logic [23:0] head;
  bit          inc_mode;

  // Observed statistics
  logic last_rd;
  int   pops;
  int   run_start;
  int   hs_falls[$];
  int   vs_falls[$];
  int   hs_widths[$];
  int   hs_low;
  logic prev_hs, prev_vs;

  typedef struct {
    logic        rst;
    logic        empty;
    logic [23:0] data;
    logic        exp_rd;
    logic        exp_hs;
    logic        exp_vs;
    logic        exp_blank;
    logic [23:0] exp_rgb;
    logic        exp_uf;
  } vec_t;

  vec_t tbl[9];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_run   = 1'b0;
    m_t     = 0;
    m_hs    = 1'b1;
    m_vs    = 1'b1;
    m_blank = 1'b1;
    m_rgb   = '0;
    m_uf    = 1'b0;
  endtask

  task automatic clear_stats();
    pops = 0;
    hs_falls.delete();
    vs_falls.delete();
    hs_widths.delete();
    hs_low  = 0;
    prev_hs = hsync;
    prev_vs = vsync;
  endtask

  function automatic bit model_in_area();
    int h, v;
    h = m_t % HT;
    v = (m_t / HT) % VT;
    return m_run && (h < HA) && (v < VA);
  endfunction

  // One pixel cycle: entered just after a falling edge with rst/fifo_empty
  // already set, leaves at the next falling edge.
  task automatic apply_stimulus();
    int          h, v;
    bit          in_area;
    logic        exp_rd;
    logic [23:0] pix;
    if (rst) model_reset();
    fifo_data = head;
    #1;
    h       = m_t % HT;
    v       = (m_t / HT) % VT;
    in_area = (h < HA) && (v < VA);
    exp_rd  = m_run && in_area && !fifo_empty && !rst;
    last_rd = read_en;
    check_output("read_en", {31'b0, read_en}, {31'b0, exp_rd});
    pix = fifo_data;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (!m_run) begin
      if (!fifo_empty) begin
        m_run     = 1'b1;
        run_start = cyc;
      end
    end else begin
      m_hs    = !((h >= HA + HF) && (h < HA + HF + HS));
      m_vs    = !((v >= VA + VF) && (v < VA + VF + VS));
      m_blank = !in_area;
      m_rgb   = exp_rd ? pix : 24'h000000;
      if (in_area && fifo_empty) m_uf = 1'b1;
      m_t++;
    end
    #1;
    check_output("outputs", {4'b0, hsync, vsync, blank, underflow, rgb},
                 {4'b0, m_hs, m_vs, m_blank, m_uf, m_rgb});
    if (last_rd) begin
      pops++;
      head = inc_mode ? head + 24'd1 : 24'($urandom);
    end
    if (prev_hs && !hsync) hs_falls.push_back(cyc);
    if (prev_vs && !vsync) vs_falls.push_back(cyc);
    if (!hsync) hs_low++;
    else if (hs_low > 0) begin
      hs_widths.push_back(hs_low);
      hs_low = 0;
    end
    prev_hs = hsync;
    prev_vs = vsync;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    fifo_empty = 1'b1;
    apply_stimulus();
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic run_to(input int target);
    int g;
    g = 0;
    while (!(m_run && (m_t % FRAME) == target) && g < 4 * FRAME) begin
      apply_stimulus();
      g++;
    end
    check_int("reach_position", (m_t % FRAME), target);
  endtask

  // Hard stop in case the scan never settles into the expected sequence
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [23:0] base;
    int          diff;

    rst        = 1'b1;
    fifo_empty = 1'b1;
    head       = '0;
    inc_mode   = 1'b1;
    fifo_data  = '0;
    model_reset();
    clear_stats();
    @(negedge clk);

    // Reset, IDLE, the IDLE->RUN cycle, first pixels, an underflow, and a
    // reset during RUN, each with explicit expected values.
    tbl[0] = '{1'b1, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000000, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000000, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000000, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 24'hA0B0C0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000000, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 24'h112233, 1'b1, 1'b1, 1'b1, 1'b0, 24'h112233, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 24'h445566, 1'b1, 1'b1, 1'b1, 1'b0, 24'h445566, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 24'h778899, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 24'hABCDEF, 1'b1, 1'b1, 1'b1, 1'b0, 24'hABCDEF, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 24'h123456, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000000, 1'b0};

    foreach (tbl[i]) begin
      rst        = tbl[i].rst;
      fifo_empty = tbl[i].empty;
      head       = tbl[i].data;
      apply_stimulus();
      check_output("tbl_read_en", {31'b0, last_rd}, {31'b0, tbl[i].exp_rd});
      check_output("tbl_outputs", {4'b0, hsync, vsync, blank, underflow, rgb},
                   {4'b0, tbl[i].exp_hs, tbl[i].exp_vs, tbl[i].exp_blank,
                    tbl[i].exp_uf, tbl[i].exp_rgb});
    end
    rst = 1'b0;

    // FIFO empty for 100 cycles after reset: nothing moves
    $display("[TB] empty FIFO after reset");
    do_reset();
    repeat (100) apply_stimulus();
    check_int("idle_pops", pops, 0);
    check_output("idle_outputs", {4'b0, hsync, vsync, blank, underflow, rgb}, {4'b0, 4'b1110, 24'h0});

    // FIFO always full with incrementing data
    $display("[TB] continuous incrementing stream");
    do_reset();
    inc_mode   = 1'b1;
    base       = 24'($urandom);
    head       = base;
    fifo_empty = 1'b0;
    apply_stimulus();
    pops = 0;
    apply_stimulus();
    check_output("first_pixel", {8'b0, rgb}, {8'b0, base});
    repeat (HT - 1) apply_stimulus();
    check_int("pops_per_line", pops, HA);
    repeat (FRAME - HT) apply_stimulus();
    check_int("pops_per_frame", pops, HA * VA);
    repeat (FRAME) apply_stimulus();
    check_int("pops_two_frames", pops, 2 * HA * VA);
    check_int("hsync_count_ok", (hs_falls.size() >= 2) ? 1 : 0, 1);
    diff = (hs_falls.size() >= 1) ? hs_falls[0] - run_start : -1;
    check_int("hsync_offset", diff, HA + HF + 1);
    diff = (hs_widths.size() >= 1) ? hs_widths[0] : -1;
    check_int("hsync_width", diff, HS);
    diff = (hs_falls.size() >= 2) ? hs_falls[1] - hs_falls[0] : -1;
    check_int("line_period", diff, HT);
    diff = (vs_falls.size() >= 1) ? vs_falls[0] - run_start : -1;
    check_int("vsync_offset", diff, (VA + VF) * HT + 1);
    diff = (vs_falls.size() >= 2) ? vs_falls[1] - vs_falls[0] : -1;
    check_int("frame_period", diff, FRAME);

    // Five empty cycles inside the visible area
    $display("[TB] visible underflow");
    do_reset();
    fifo_empty = 1'b0;
    run_to(3 * HT + 5);
    pops       = 0;
    fifo_empty = 1'b1;
    repeat (5) apply_stimulus();
    check_int("underflow_pops", pops, 0);
    check_output("underflow_rgb", {8'b0, rgb}, 32'h0);
    check_output("underflow_set", {31'b0, underflow}, 32'h1);
    fifo_empty = 1'b0;
    repeat (FRAME) apply_stimulus();
    check_output("underflow_sticky", {31'b0, underflow}, 32'h1);

    // Asynchronous reset in the middle of a frame
    $display("[TB] mid-frame reset");
    run_to(5 * HT + 10);
    #2;
    rst = 1'b1;
    #1;
    check_output("async_rst_hsync", {31'b0, hsync}, 32'h1);
    check_output("async_rst_vsync", {31'b0, vsync}, 32'h1);
    check_output("async_rst_blank", {31'b0, blank}, 32'h1);
    check_output("async_rst_rgb", {8'b0, rgb}, 32'h0);
    check_output("async_rst_underflow", {31'b0, underflow}, 32'h0);
    check_output("async_rst_read_en", {31'b0, read_en}, 32'h0);
    apply_stimulus();
    rst        = 1'b0;
    fifo_empty = 1'b1;
    repeat (5) apply_stimulus();
    clear_stats();
    base       = 24'($urandom);
    head       = base;
    fifo_empty = 1'b0;
    apply_stimulus();
    apply_stimulus();
    check_output("restart_first_pixel", {8'b0, rgb}, {8'b0, base});
    repeat (HT) apply_stimulus();
    diff = (hs_falls.size() >= 1) ? hs_falls[0] - run_start : -1;
    check_int("restart_hsync_offset", diff, HA + HF + 1);

    // FIFO empties only while blanked: never an underflow
    $display("[TB] empty only during blanking");
    do_reset();
    fifo_empty = 1'b0;
    apply_stimulus();
    pops = 0;
    repeat (FRAME) begin
      fifo_empty = model_in_area() ? 1'b0 : 1'($urandom_range(0, 1));
      apply_stimulus();
    end
    check_int("blank_empty_pops", pops, HA * VA);
    check_output("blank_empty_no_underflow", {31'b0, underflow}, 32'h0);

    // Random FIFO occupancy and random pixel data
    $display("[TB] random stream");
    do_reset();
    inc_mode = 1'b0;
    head     = 24'($urandom);
    repeat (2 * FRAME) begin
      fifo_empty = ($urandom_range(0, 9) < 3);
      apply_stimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
